decryption_core: RTL

DECRYPTION_CORE -- requirements
Module: decryption_core

---
 rtl/crypto_pkg.sv | 26 ++
 rtl/mod_reduce.sv | 23 ++
 rtl/decryption_core.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/crypto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_pkg
// Description : Shared constants and state encoding for the character
//               encryption/decryption cores.
//               P_MOD      - modulus of the character ring (227)
//               MODE_ENC   - mode code selecting encryption
//               MODE_DEC   - mode code selecting decryption
//               dec_state_t- decryption FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package crypto_pkg;

    localparam logic [8:0] P_MOD    = 9'd227;
    localparam logic [1:0] MODE_ENC = 2'b10;
    localparam logic [1:0] MODE_DEC = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/mod_reduce.sv
`default_nettype none
// ============================================================================
// Module      : mod_reduce
// Description : Single conditional subtraction of P_MOD. Valid for any input
//               below 2*P_MOD, which covers the sum of two in-range operands.
// Ports       : sum_in  [8:0] in  - unreduced value
//               result  [7:0] out - sum_in mod P_MOD
// Revision    : 1.0 - initial release
// ============================================================================
module mod_reduce
    import crypto_pkg::*;
(
    input  logic [8:0] sum_in,
    output logic [7:0] result
);

    logic [8:0] w_diff;

    assign w_diff = sum_in - P_MOD;
    assign result = (sum_in >= P_MOD) ? w_diff[7:0] : sum_in[7:0];

endmodule
`default_nettype wire

// File: rtl/decryption_core.sv
`default_nettype none
// ============================================================================
// Module      : decryption_core
// Description : Recovers a character as (Char_ciphertext + Public_key) mod 227
//               through a four-state handshake FSM (IDLE/ADD/REDUCE/DONE).
//               The result is held with P_ready until P_ack is seen in DONE.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               mode  [1:0]         - 2'b11 decrypt, anything else inactive
//               start               - request strobe, honoured only in IDLE
//               Char_ciphertext[7:0]- ciphertext character
//               Public_key     [7:0]- key
//               P_ack               - consumer acknowledge
//               Plaintext      [7:0]- recovered character
//               P_ready             - result valid, held until acknowledged
//               busy                - high whenever not IDLE
//               P_err               - operand range error (DEC_RANGE_CHECK_EN)
// Options     : DEC_RANGE_CHECK_EN - reject operands >= 227 at capture time
// Revision    : 1.0 - initial release
// ============================================================================
module decryption_core
    import crypto_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic [7:0] Char_ciphertext,
    input  logic [7:0] Public_key,
    input  logic       P_ack,
    output logic [7:0] Plaintext,
    output logic       P_ready,
    output logic       busy
`ifdef DEC_RANGE_CHECK_EN
    ,
    output logic       P_err
`endif
);

    dec_state_t r_state;
    dec_state_t w_state_next;

    logic [7:0] r_op_c;
    logic [7:0] r_op_k;
    logic [8:0] r_sum;
    logic [7:0] r_plaintext;
    logic       r_ready;
    logic [7:0] w_reduced;

    logic       w_mode_dec;
    logic       w_capture;
    logic       w_sum_en;
    logic       w_result_en;
    logic       w_ack;

`ifdef DEC_RANGE_CHECK_EN
    logic       w_range_bad;
    logic       w_err_set;
    logic       w_err_clr;
    logic       r_err;

    assign w_range_bad = ({1'b0, Char_ciphertext} >= P_MOD) ||
                         ({1'b0, Public_key}      >= P_MOD);
`endif

    assign w_mode_dec = (mode == MODE_DEC);

    mod_reduce u_mod_reduce (
        .sum_in (r_sum),
        .result (w_reduced)
    );

    // Next-state and datapath enables
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_sum_en     = 1'b0;
        w_result_en  = 1'b0;
        w_ack        = 1'b0;
`ifdef DEC_RANGE_CHECK_EN
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (start && w_mode_dec) begin
`ifdef DEC_RANGE_CHECK_EN
                    if (w_range_bad) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_err_clr    = 1'b1;
                        w_capture    = 1'b1;
                        w_state_next = ADD;
                    end
`else
                    w_capture    = 1'b1;
                    w_state_next = ADD;
`endif
                end
            end
            ADD: begin
                // Leaving decrypt mode mid-computation abandons the request.
                if (!w_mode_dec) begin
                    w_state_next = IDLE;
                end else begin
                    w_sum_en     = 1'b1;
                    w_state_next = REDUCE;
                end
            end
            REDUCE: begin
                if (!w_mode_dec) begin
                    w_state_next = IDLE;
                end else begin
                    w_result_en  = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Mode is deliberately ignored here: the held result is final.
                if (P_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op_c      <= 8'h00;
            r_op_k      <= 8'h00;
            r_sum       <= 9'h000;
            r_plaintext <= 8'h00;
            r_ready     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_op_c <= Char_ciphertext;
                r_op_k <= Public_key;
            end
            if (w_sum_en) begin
                r_sum <= {1'b0, r_op_c} + {1'b0, r_op_k};
            end
            if (w_result_en) begin
                r_plaintext <= w_reduced;
                r_ready     <= 1'b1;
            end else if (w_ack) begin
                r_ready <= 1'b0;
            end
        end
    end

`ifdef DEC_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign P_err = r_err;
`endif

    assign Plaintext = r_plaintext;
    assign P_ready   = r_ready;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
